align_to_32: RTL and testbench

ALIGN_TO_32 -- requirements
Module: align_to_32

---
 rtl/align_to_32.sv | 68 ++++++
 tb/tb_align_to_32.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/align_to_32.sv
// rtl/align_to_32.sv - zero/sign-extend a WIDTH-bit field to 32 bits, with a registered capture stage
module align_to_32 #(
    parameter int WIDTH    = 1,
    parameter int SIGN_EXT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             freeze,
    output logic [31:0]      out,
    output logic [31:0]      out_q,
    output logic             out_valid,
    output logic             changed
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("align_to_32: WIDTH must be within 1..32");
    end
    if (SIGN_EXT != 0 && SIGN_EXT != 1) begin : g_bad_sign_ext
        $error("align_to_32: SIGN_EXT must be 0 or 1");
    end

    logic [31:0] aligned;

    if (WIDTH == 32) begin : g_full
        assign aligned = in;
    end else begin : g_ext
        logic ext_bit;
        assign ext_bit = (SIGN_EXT != 0) ? in[WIDTH-1] : 1'b0;
        assign aligned = {{(32-WIDTH){ext_bit}}, in};
    end

    assign out = aligned;

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        changed_q, changed_d;

    // The first capture after reset always pulses, even if it matches the cleared register.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (in_valid && !freeze) begin
            data_d    = aligned;
            valid_d   = 1'b1;
            changed_d = !valid_q || (aligned != data_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 32'h0000_0000;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign out_q     = data_q;
    assign out_valid = valid_q;
    assign changed   = changed_q;

endmodule

// File: tb/tb_align_to_32.sv
// tb/tb_align_to_32.sv - scoreboard bench driving six width/extension variants from one shared stream
module tb_align_to_32;

    localparam int N = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             freeze;
    logic [31:0]      din;
    logic [N-1:0][31:0] o;
    logic [N-1:0][31:0] oq;
    logic [N-1:0]     ov;
    logic [N-1:0]     ch;

    always #5 clk = ~clk;

    align_to_32 #(.WIDTH(1),  .SIGN_EXT(0)) u_w1   (.clk(clk), .rst(rst), .in(din[0:0]),  .in_valid(in_valid), .freeze(freeze), .out(o[0]), .out_q(oq[0]), .out_valid(ov[0]), .changed(ch[0]));
    align_to_32 #(.WIDTH(5),  .SIGN_EXT(1)) u_w5s  (.clk(clk), .rst(rst), .in(din[4:0]),  .in_valid(in_valid), .freeze(freeze), .out(o[1]), .out_q(oq[1]), .out_valid(ov[1]), .changed(ch[1]));
    align_to_32 #(.WIDTH(5),  .SIGN_EXT(0)) u_w5z  (.clk(clk), .rst(rst), .in(din[4:0]),  .in_valid(in_valid), .freeze(freeze), .out(o[2]), .out_q(oq[2]), .out_valid(ov[2]), .changed(ch[2]));
    align_to_32 #(.WIDTH(4),  .SIGN_EXT(0)) u_w4   (.clk(clk), .rst(rst), .in(din[3:0]),  .in_valid(in_valid), .freeze(freeze), .out(o[3]), .out_q(oq[3]), .out_valid(ov[3]), .changed(ch[3]));
    align_to_32 #(.WIDTH(2),  .SIGN_EXT(0)) u_w2   (.clk(clk), .rst(rst), .in(din[1:0]),  .in_valid(in_valid), .freeze(freeze), .out(o[4]), .out_q(oq[4]), .out_valid(ov[4]), .changed(ch[4]));
    align_to_32 #(.WIDTH(32), .SIGN_EXT(0)) u_w32  (.clk(clk), .rst(rst), .in(din),       .in_valid(in_valid), .freeze(freeze), .out(o[5]), .out_q(oq[5]), .out_valid(ov[5]), .changed(ch[5]));

    typedef struct packed {
        logic [N-1:0][31:0] q;
        logic [N-1:0]       v;
        logic [N-1:0]       c;
    } exp_t;

    exp_t exp_queue[$];
    exp_t model;

    int n_checks = 0;
    int n_passed = 0;

    function automatic int width_of(input int i);
        case (i)
            0: return 1;
            1: return 5;
            2: return 5;
            3: return 4;
            4: return 2;
            default: return 32;
        endcase
    endfunction

    function automatic bit sext_of(input int i);
        return (i == 1);
    endfunction

    function automatic logic [31:0] align(input logic [31:0] v, input int w, input bit se);
        logic [31:0] r;
        for (int b = 0; b < 32; b++)
            r[b] = (b < w) ? v[b] : (se ? v[w-1] : 1'b0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_passed++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    task automatic step(input logic r, input logic iv, input logic fz, input logic [31:0] d);
        exp_t e;
        logic [31:0] a;
        @(negedge clk);
        rst = r; in_valid = iv; freeze = fz; din = d;
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("out[%0d]", i), o[i], align(d, width_of(i), sext_of(i)));
        for (int i = 0; i < N; i++) begin
            if (r) begin
                model.q[i] = 32'h0; model.v[i] = 1'b0; model.c[i] = 1'b0;
            end else if (iv && !fz) begin
                a = align(d, width_of(i), sext_of(i));
                model.c[i] = !model.v[i] || (a != model.q[i]);
                model.q[i] = a;
                model.v[i] = 1'b1;
            end else begin
                model.c[i] = 1'b0;
            end
        end
        exp_queue.push_back(model);
        @(posedge clk);
        #1;
        if (exp_queue.size() == 0) begin
            check("scoreboard_empty", 32'h1, 32'h0);
        end else begin
            e = exp_queue.pop_front();
            for (int i = 0; i < N; i++) begin
                check($sformatf("out_q[%0d]", i),     oq[i],        e.q[i]);
                check($sformatf("out_valid[%0d]", i), {31'h0, ov[i]}, {31'h0, e.v[i]});
                check($sformatf("changed[%0d]", i),   {31'h0, ch[i]}, {31'h0, e.c[i]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; freeze = 1'b0; din = 32'h0;
        model = '0;

        step(1, 0, 0, 32'h0);
        check("rst_out_q",     oq[3], 32'h0);
        check("rst_out_valid", {31'h0, ov[3]}, 32'h0);
        check("rst_changed",   {31'h0, ch[3]}, 32'h0);

        // Combinational extension vectors
        step(0, 0, 0, 32'h1);
        check("w1_one", o[0], 32'h0000_0001);
        step(0, 0, 0, 32'h0);
        check("w1_zero", o[0], 32'h0);
        step(0, 0, 0, 32'h16);
        check("w5_sext", o[1], 32'hFFFF_FFF6);
        check("w5_zext", o[2], 32'h0000_0016);

        // First capture and repeat of the same value
        step(1, 0, 0, 32'h0);
        step(0, 1, 0, 32'hA);
        check("w4_cap_q",  oq[3], 32'h0000_000A);
        check("w4_cap_v",  {31'h0, ov[3]}, 32'h1);
        check("w4_cap_ch", {31'h0, ch[3]}, 32'h1);
        step(0, 1, 0, 32'hA);
        check("w4_same_ch", {31'h0, ch[3]}, 32'h0);
        step(0, 0, 0, 32'h5);
        check("idle_hold_q", oq[3], 32'h0000_000A);

        // Freeze holds registers while out keeps tracking
        step(0, 1, 0, 32'h1);
        step(0, 1, 1, 32'h3);
        check("w2_frz_q",   oq[4], 32'h1);
        check("w2_frz_ch",  {31'h0, ch[4]}, 32'h0);
        check("w2_frz_out", o[4], 32'h3);

        // Reset wins over a capture in the same cycle
        step(1, 1, 0, 32'hDEAD_BEEF);
        check("w32_rst_q", oq[5], 32'h0);
        check("w32_rst_v", {31'h0, ov[5]}, 32'h0);
        step(0, 1, 0, 32'hDEAD_BEEF);
        check("w32_cap_q",  oq[5], 32'hDEAD_BEEF);
        check("w32_cap_ch", {31'h0, ch[5]}, 32'h1);

        // Capture of zero right after a mid-stream reset still pulses
        step(1, 1, 1, 32'h0);
        step(0, 1, 0, 32'h0);
        check("zero_after_rst_ch", {31'h0, ch[3]}, 32'h1);
        check("zero_after_rst_q",  oq[3], 32'h0);

        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0) ? {28'h0, 4'($urandom_range(0, 3))} : $urandom);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
